// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions.
//   mul_state_t : control states of the iterative multiplier
//   reg_idx_t   : register-file index (8 registers)
//   NZP_*       : one-hot {N,Z,P} condition-code encodings
package lc3_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_WB
    } mul_state_t;

    typedef logic [2:0] reg_idx_t;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

endpackage

// File: rtl/regfile_mul_unit.sv
// Iterative shift-add multiplier placed between the register-file read ports
// and its write port. It returns the low WIDTH bits of sr1*sr2 through a
// one-cycle writeback strobe, together with the matching N/Z/P codes.
//
// Ports
//   clk      in   single clock, posedge
//   reset    in   asynchronous, active-low; shared with the register file
//   start    in   request a multiply; only looked at in IDLE
//   sr1_in   in   multiplicand (register-file SR1_OUT)
//   sr2_in   in   multiplier   (register-file SR2_OUT)
//   dr_in    in   destination register index
//   busy     out  high in RUN and WB; holds off other register-file writes
//   wb_data  out  result to register-file D_In, zero outside WB
//   wb_dr    out  latched destination to register-file DR
//   ld_reg   out  one-cycle write strobe to register-file LD_REG
//   nzp      out  {N,Z,P} of wb_data, zero outside WB
module regfile_mul_unit
    import lc3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] sr1_in,
    input  logic [WIDTH-1:0] sr2_in,
    input  reg_idx_t         dr_in,
    output logic             busy,
    output logic [WIDTH-1:0] wb_data,
    output reg_idx_t         wb_dr,
    output logic             ld_reg,
    output logic [2:0]       nzp
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: every process that holds state uses non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each output of this block gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MUL_IDLE: if (start) state_d = MUL_RUN;
            // The counter was loaded with WIDTH, so the last iteration is the
            // one where it reads 1: RUN lasts exactly WIDTH cycles.
            MUL_RUN:  if (cnt_q == CNT_W'(1)) state_d = MUL_WB;
            MUL_WB:   state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Datapath. The low WIDTH bits of the product do not depend on operand
    // signedness, so the accumulator simply wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            wb_dr <= '0;
        end else begin
            unique case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        acc_q <= '0;
                        a_q   <= sr1_in;
                        b_q   <= sr2_in;
                        cnt_q <= CNT_W'(WIDTH);
                        wb_dr <= dr_in;
                    end
                end
                MUL_RUN: begin
                    if (b_q[0]) acc_q <= acc_q + a_q;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops busy/ld_reg immediately and aborts any pending write.
    always_comb begin
        busy    = (state_q != MUL_IDLE);
        ld_reg  = (state_q == MUL_WB);
        wb_data = '0;
        nzp     = 3'b000;
        if (state_q == MUL_WB) begin
            wb_data = acc_q;
            if (acc_q[WIDTH-1])   nzp = NZP_N;
            else if (acc_q == '0) nzp = NZP_Z;
            else                  nzp = NZP_P;
        end
    end

endmodule

// File: tb/tb_regfile_mul_unit.sv
// Directed and back-to-back random checks for regfile_mul_unit.
module tb_regfile_mul_unit;
    import lc3_pkg::*;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] sr1_in;
    logic [WIDTH-1:0] sr2_in;
    reg_idx_t         dr_in;
    logic             busy;
    logic [WIDTH-1:0] wb_data;
    reg_idx_t         wb_dr;
    logic             ld_reg;
    logic [2:0]       nzp;

    int errors = 0;
    int checks = 0;

    regfile_mul_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sr1_in  (sr1_in),
        .sr2_in  (sr2_in),
        .dr_in   (dr_in),
        .busy    (busy),
        .wb_data (wb_data),
        .wb_dr   (wb_dr),
        .ld_reg  (ld_reg),
        .nzp     (nzp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until ld_reg is seen (bounded); returns 0 on timeout.
    task automatic wait_wb(output int n);
        n = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            if (ld_reg) begin
                n = i;
                break;
            end
        end
    endtask

    // Watches for a spurious write over a number of cycles.
    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ld_reg || busy) seen++;
        end
        check(tag, seen, 0);
    endtask

    // Single multiply from IDLE: drive at a negedge, pulse start for one cycle.
    task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input reg_idx_t dr, input logic [15:0] exp_data,
                          input logic [2:0] exp_nzp);
        int n;
        @(negedge clk);
        sr1_in = a;
        sr2_in = b;
        dr_in  = dr;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        sr1_in = ~a;
        sr2_in = ~b;
        dr_in  = ~dr;
        check({tag, "_busy"}, busy, 1'b1);
        wait_wb(n);
        // drive negedge + 16 RUN negedges + WB negedge = 17 from the drive point
        check({tag, "_lat"}, n + 1, 17);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_dr"}, wb_dr, dr);
        check({tag, "_nzp"}, nzp, exp_nzp);
        @(negedge clk);
        check({tag, "_pulse"}, {busy, ld_reg, nzp}, 5'b0);
    endtask

    initial begin
        int n;
        logic [15:0] ra, rb;
        logic [31:0] prod;

        reset  = 1'b0;
        start  = 1'b0;
        sr1_in = '0;
        sr2_in = '0;
        dr_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  busy, 1'b0);
        check("rst_ld",    ld_reg, 1'b0);
        check("rst_data",  wb_data, 16'h0000);
        check("rst_nzp",   nzp, 3'b000);
        check("rst_dr",    wb_dr, 3'd0);
        reset = 1'b1;
        expect_quiet("idle_hold", 3);

        // 1..3: basic product, negative result, wrap to zero
        do_mul("t1", 16'h0003, 16'h0005, 3'd2, 16'h000F, NZP_P);
        do_mul("t2", 16'hFFFF, 16'h0002, 3'd3, 16'hFFFE, NZP_N);
        do_mul("t3", 16'h0100, 16'h0100, 3'd6, 16'h0000, NZP_Z);

        // 4: start during RUN and during WB is ignored
        @(negedge clk);
        sr1_in = 16'h0007; sr2_in = 16'h0009; dr_in = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        sr1_in = 16'h1234; sr2_in = 16'h0011; dr_in = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_wb(n);
        check("t4_seen", n != 0, 1'b1);
        check("t4_data", wb_data, 16'h003F);
        check("t4_dr",   wb_dr, 3'd1);
        start = 1'b1;               // present during WB, sampled at WB's last edge
        @(negedge clk);
        start = 1'b0;
        expect_quiet("t4_one_write", 20);

        // 5: reset mid-RUN aborts without a write
        @(negedge clk);
        sr1_in = 16'h0005; sr2_in = 16'h0005; dr_in = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("t5_running", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_abort", {busy, ld_reg, wb_data}, 18'h0);
        check("t5_dr_clr", wb_dr, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        expect_quiet("t5_no_write", 20);
        do_mul("t5_fresh", 16'h0002, 16'h0003, 3'd7, 16'h0006, NZP_P);

        // 6: start held high, new operands each IDLE cycle, writes every 18 cycles
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin ra = 16'h8000; rb = 16'h0001; end
            if (i == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; end
            sr1_in = ra;
            sr2_in = rb;
            dr_in  = reg_idx_t'(i);
            prod   = 32'(ra) * 32'(rb);
            @(negedge clk);
            sr1_in = ~ra;
            sr2_in = ~rb;
            dr_in  = ~reg_idx_t'(i);
            wait_wb(n);
            check("b2b_period", n + 1, 17);
            check("b2b_data", wb_data, prod[15:0]);
            check("b2b_dr", wb_dr, reg_idx_t'(i));
            @(negedge clk);         // IDLE cycle: next operands accepted on its edge
        end
        start = 1'b0;
        expect_quiet("b2b_drain", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
